// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit unsigned adder/subtractor.
// Each stage adds one CHUNK-bit slice. The carry is registered between stages.
// Upper operand slices shift down one slice per stage (skew). Finished result
// slices enter at the top of the result word and shift down (deskew), so that
// slice k lands at bit position k*CHUNK when it reaches the last stage.

module pipe_adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    // One CHUNK-bit ripple slice; this carry chain sets the critical path.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
endmodule

module pipe_adder #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic             iStall,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    input  logic             iSub,
    output logic             oValid,
    output logic [WIDTH-1:0] oFnc,
    output logic             oC,
    output logic             oZero
);
    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("pipe_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    // Operand B after optional inversion; subtract is A + ~B + 1.
    logic [WIDTH-1:0] b_in;
    assign b_in = iSub ? ~iB : iB;

    // Per-stage state. a/b hold the not-yet-added upper slices, shifted so the
    // next slice to add always sits in the low CHUNK bits.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] z_q, z_d;
    logic [STAGES-1:0] v_q, v_d;

    logic [STAGES-1:0][CHUNK-1:0] sl_a, sl_b, sl_s;
    logic [STAGES-1:0]            sl_ci, sl_co;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a  (sl_a[k]),
            .b  (sl_b[k]),
            .ci (sl_ci[k]),
            .s  (sl_s[k]),
            .co (sl_co[k])
        );
    end

    // Next-state for every stage: feed slice inputs, shift operands and results.
    always_comb begin
        sl_a[0]  = iA[CHUNK-1:0];
        sl_b[0]  = b_in[CHUNK-1:0];
        sl_ci[0] = iSub | iC;
        a_d[0]   = iA >> CHUNK;
        b_d[0]   = b_in >> CHUNK;
        r_d[0]   = WIDTH'(sl_s[0]) << (WIDTH - CHUNK);
        c_d[0]   = sl_co[0];
        z_d[0]   = (sl_s[0] == '0);
        v_d[0]   = iValid;
        for (int k = 1; k < STAGES; k++) begin
            sl_a[k]  = a_q[k-1][CHUNK-1:0];
            sl_b[k]  = b_q[k-1][CHUNK-1:0];
            sl_ci[k] = c_q[k-1];
            a_d[k]   = a_q[k-1] >> CHUNK;
            b_d[k]   = b_q[k-1] >> CHUNK;
            r_d[k]   = (r_q[k-1] >> CHUNK) | (WIDTH'(sl_s[k]) << (WIDTH - CHUNK));
            c_d[k]   = sl_co[k];
            z_d[k]   = z_q[k-1] & (sl_s[k] == '0);
            v_d[k]   = v_q[k-1];
        end
    end

    // Pipeline registers: async clear, whole pipe frozen while stalled.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            a_q <= '{default: '0};
            b_q <= '{default: '0};
            r_q <= '{default: '0};
            c_q <= '0;
            z_q <= '0;
            v_q <= '0;
        end else if (!iStall) begin
            a_q <= a_d;
            b_q <= b_d;
            r_q <= r_d;
            c_q <= c_d;
            z_q <= z_d;
            v_q <= v_d;
        end
    end

    assign oValid = v_q[STAGES-1];
    assign oFnc   = r_q[STAGES-1];
    assign oC     = c_q[STAGES-1];
    assign oZero  = z_q[STAGES-1];
endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed checks of the 24/8 adder plus a random sweep over
// (8,8), (32,4) and (11,11). A result is registered by the STAGES-th rising
// edge counting the issue edge itself (one edge for a single-stage adder).

module tb_pipe_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld = 1'b0;
    logic        stall = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic [31:0] a32 = '0;
    logic [31:0] b32 = '0;

    logic        v24, c24, z24;
    logic [23:0] f24;
    logic        v8, c8, z8;
    logic [7:0]  f8;
    logic        v32, c32, z32;
    logic [31:0] f32;
    logic        v11, c11, z11;
    logic [10:0] f11;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(24), .CHUNK(8)) dut24 (
        .iClk(clk), .iRst(rst), .iValid(vld), .iStall(stall), .iA(a32[23:0]), .iB(b32[23:0]),
        .iC(cin), .iSub(sub), .oValid(v24), .oFnc(f24), .oC(c24), .oZero(z24));
    pipe_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .iClk(clk), .iRst(rst), .iValid(vld), .iStall(stall), .iA(a32[7:0]), .iB(b32[7:0]),
        .iC(cin), .iSub(sub), .oValid(v8), .oFnc(f8), .oC(c8), .oZero(z8));
    pipe_adder #(.WIDTH(32), .CHUNK(4)) dut32 (
        .iClk(clk), .iRst(rst), .iValid(vld), .iStall(stall), .iA(a32), .iB(b32),
        .iC(cin), .iSub(sub), .oValid(v32), .oFnc(f32), .oC(c32), .oZero(z32));
    pipe_adder #(.WIDTH(11), .CHUNK(11)) dut11 (
        .iClk(clk), .iRst(rst), .iValid(vld), .iStall(stall), .iA(a32[10:0]), .iB(b32[10:0]),
        .iC(cin), .iSub(sub), .oValid(v11), .oFnc(f11), .oC(c11), .oZero(z11));

    // Drive one cycle of inputs at the falling edge.
    task automatic put(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s, input logic st);
        @(negedge clk);
        vld = v; a32 = a; b32 = b; cin = c; sub = s; stall = st;
    endtask

    // Advance past one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {carry, sum} of a w-bit add/sub, independent of slicing.
    function automatic logic [32:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic c, input logic s);
        logic [32:0] m, ra, rb;
        m  = (33'd1 << w) - 33'd1;
        ra = {1'b0, a} & m;
        rb = s ? (~{1'b0, b} & m) : ({1'b0, b} & m);
        return ra + rb + (s ? 33'd1 : {32'd0, c});
    endfunction

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL rst0_valid got=%b exp=0", v24); end
        checks++; if (f24 !== 24'h0) begin errors++; $display("FAIL rst0_fnc got=%h exp=000000", f24); end
        checks++; if (c24 !== 1'b0) begin errors++; $display("FAIL rst0_c got=%b exp=0", c24); end
        checks++; if (z24 !== 1'b0) begin errors++; $display("FAIL rst0_zero got=%b exp=0", z24); end
        @(negedge clk); rst = 1'b0;
        // Put a non-zero result on the outputs, then reset between edges with stall held.
        put(1, 32'hFFFFFF, 32'h2, 0, 0, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (v24 !== 1'b1 || f24 !== 24'h000001 || c24 !== 1'b1)
            begin errors++; $display("FAIL pre_rst got=%b/%h/%b exp=1/000001/1", v24, f24, c24); end
        @(negedge clk); stall = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL async_rst_valid got=%b exp=0", v24); end
        checks++; if (f24 !== 24'h0) begin errors++; $display("FAIL async_rst_fnc got=%h exp=000000", f24); end
        checks++; if (c24 !== 1'b0) begin errors++; $display("FAIL async_rst_c got=%b exp=0", c24); end
        checks++; if (z24 !== 1'b0) begin errors++; $display("FAIL async_rst_zero got=%b exp=0", z24); end
        @(negedge clk); rst = 1'b0; stall = 1'b0;
        tick();
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL post_rst_idle got=%b exp=0", v24); end
        put(1, 4, 5, 0, 0, 0); tick();
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL first_lat1 got=%b exp=0", v24); end
        put(0, 0, 0, 0, 0, 0); tick();
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL first_lat2 got=%b exp=0", v24); end
        tick();
        checks++; if (v24 !== 1'b1 || f24 !== 24'd9)
            begin errors++; $display("FAIL first_lat3 got=%b/%h exp=1/000009", v24, f24); end
    endtask

    task automatic test_add_ripple();
        put(1, 32'h00FFFF, 32'h000001, 0, 0, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (v24 !== 1'b1) begin errors++; $display("FAIL ripple_valid got=%b exp=1", v24); end
        checks++; if (f24 !== 24'h010000) begin errors++; $display("FAIL ripple_fnc got=%h exp=010000", f24); end
        checks++; if (c24 !== 1'b0 || z24 !== 1'b0) begin errors++; $display("FAIL ripple_flags got=c%b z%b exp=c0 z0", c24, z24); end
        // Carry-in ripples through a full slice.
        put(1, 32'h0000FF, 32'h0, 1, 0, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (f24 !== 24'h000100) begin errors++; $display("FAIL carry_in_fnc got=%h exp=000100", f24); end
    endtask

    task automatic test_overflow();
        put(1, 32'hFFFFFF, 32'h000001, 0, 0, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (f24 !== 24'h000000) begin errors++; $display("FAIL ovf_fnc got=%h exp=000000", f24); end
        checks++; if (c24 !== 1'b1) begin errors++; $display("FAIL ovf_c got=%b exp=1", c24); end
        checks++; if (z24 !== 1'b1) begin errors++; $display("FAIL ovf_zero got=%b exp=1", z24); end
    endtask

    task automatic test_subtract();
        put(1, 5, 7, 1, 1, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (f24 !== 24'hFFFFFE) begin errors++; $display("FAIL sub_borrow_fnc got=%h exp=fffffe", f24); end
        checks++; if (c24 !== 1'b0 || z24 !== 1'b0) begin errors++; $display("FAIL sub_borrow_flags got=c%b z%b exp=c0 z0", c24, z24); end
        put(1, 32'h123456, 32'h123456, 0, 1, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (f24 !== 24'h0 || c24 !== 1'b1 || z24 !== 1'b1)
            begin errors++; $display("FAIL sub_equal got=%h c%b z%b exp=000000 c1 z1", f24, c24, z24); end
    endtask

    task automatic test_stall_hold();
        put(1, 3, 4, 0, 0, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        // Stall with a valid op presented: output holds, op is dropped.
        for (int i = 0; i < 3; i++) begin
            put(1, 100, 100, 0, 0, 1); tick();
            checks++; if (v24 !== 1'b1 || f24 !== 24'd7)
                begin errors++; $display("FAIL stall_hold%0d got=%b/%h exp=1/000007", i, v24, f24); end
        end
        put(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL stall_drop%0d got=%b exp=0", i, v24); end
        end
    endtask

    task automatic test_back_to_back();
        put(1, 1, 1, 0, 0, 0); tick();
        put(1, 2, 2, 0, 0, 0); tick();
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL b2b_e2 got=%b exp=0", v24); end
        put(1, 32'h555, 32'h555, 0, 0, 1); tick();
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL b2b_stall1 got=%b exp=0", v24); end
        put(1, 32'h555, 32'h555, 0, 0, 1); tick();
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL b2b_stall2 got=%b exp=0", v24); end
        put(1, 32'h800000, 32'h800000, 0, 0, 0); tick();
        checks++; if (v24 !== 1'b1 || f24 !== 24'd2 || c24 !== 1'b0)
            begin errors++; $display("FAIL b2b_r0 got=%b/%h/%b exp=1/000002/0", v24, f24, c24); end
        put(1, 10, 3, 0, 1, 0); tick();
        checks++; if (v24 !== 1'b1 || f24 !== 24'd4)
            begin errors++; $display("FAIL b2b_r1 got=%b/%h exp=1/000004", v24, f24); end
        put(0, 0, 0, 0, 0, 0); tick();
        checks++; if (v24 !== 1'b1 || f24 !== 24'd0 || c24 !== 1'b1 || z24 !== 1'b1)
            begin errors++; $display("FAIL b2b_r2 got=%b/%h/c%b/z%b exp=1/000000/c1/z1", v24, f24, c24, z24); end
        tick();
        checks++; if (v24 !== 1'b1 || f24 !== 24'd7 || c24 !== 1'b1 || z24 !== 1'b0)
            begin errors++; $display("FAIL b2b_r3 got=%b/%h/c%b/z%b exp=1/000007/c1/z0", v24, f24, c24, z24); end
        tick();
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL b2b_tail got=%b exp=0", v24); end
    endtask

    task automatic test_reset_midstream();
        put(1, 32'h111, 32'h222, 0, 0, 0); tick();
        put(1, 32'h333, 32'h444, 0, 0, 0); tick();
        @(negedge clk); vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL mid_rst_now got=%b exp=0", v24); end
        tick();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (v24 !== 1'b0) begin errors++; $display("FAIL mid_rst_flush%0d got=%b exp=0", i, v24); end
        end
        put(1, 32'h123456, 32'h111111, 0, 0, 0); tick();
        put(0, 0, 0, 0, 0, 0); tick(); tick();
        checks++; if (v24 !== 1'b1 || f24 !== 24'h234567 || c24 !== 1'b0 || z24 !== 1'b0)
            begin errors++; $display("FAIL mid_rst_next got=%b/%h/c%b/z%b exp=1/234567/c0/z0", v24, f24, c24, z24); end
    endtask

    task automatic test_sweep();
        logic [31:0] a, b;
        logic        c, s;
        logic [32:0] r8, r11, r24, r32;
        for (int i = 0; i < 12; i++) begin
            a = $urandom(); b = $urandom();
            c = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1));
            if (i == 0) begin a = 32'hFFFFFFFF; b = 32'h1; c = 1'b0; s = 1'b0; end
            if (i == 1) begin b = a; s = 1'b1; end
            r8 = model(8, a, b, c, s); r11 = model(11, a, b, c, s);
            r24 = model(24, a, b, c, s); r32 = model(32, a, b, c, s);
            put(1, a, b, c, s, 0); tick();
            checks++; if (v8 !== 1'b1 || f8 !== r8[7:0] || c8 !== r8[8] || z8 !== (r8[7:0] == 8'd0))
                begin errors++; $display("FAIL sweep8_%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", i, v8, f8, c8, z8, r8[7:0], r8[8], r8[7:0] == 8'd0); end
            checks++; if (v11 !== 1'b1 || f11 !== r11[10:0] || c11 !== r11[11] || z11 !== (r11[10:0] == 11'd0))
                begin errors++; $display("FAIL sweep11_%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", i, v11, f11, c11, z11, r11[10:0], r11[11], r11[10:0] == 11'd0); end
            put(0, 0, 0, 0, 0, 0);
            for (int e = 2; e <= 8; e++) begin
                tick();
                if (e == 3) begin
                    checks++; if (v24 !== 1'b1 || f24 !== r24[23:0] || c24 !== r24[24] || z24 !== (r24[23:0] == 24'd0))
                        begin errors++; $display("FAIL sweep24_%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", i, v24, f24, c24, z24, r24[23:0], r24[24], r24[23:0] == 24'd0); end
                end
                if (e == 7) begin
                    checks++; if (v32 !== 1'b0) begin errors++; $display("FAIL sweep32_early_%0d got=%b exp=0", i, v32); end
                end
            end
            checks++; if (v32 !== 1'b1 || f32 !== r32[31:0] || c32 !== r32[32] || z32 !== (r32[31:0] == 32'd0))
                begin errors++; $display("FAIL sweep32_%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", i, v32, f32, c32, z32, r32[31:0], r32[32], r32[31:0] == 32'd0); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_ripple();
        test_overflow();
        test_subtract();
        test_stall_hold();
        test_back_to_back();
        test_reset_midstream();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined integer adder/subtractor for the FP normalisation datapath; it replaces the single-bit half adder primitive in wide mantissa and exponent arithmetic. WIDTH-bit operands are split into CHUNK-bit slices, one slice added per pipeline stage with the carry registered between stages. This gives one result per cycle at fixed latency, with a valid flag, a global stall, add/subtract mode, and carry and zero flags.

## Interface
- WIDTH, 24: operand/result width in bits; must be an exact multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8: bits added per stage; STAGES = WIDTH/CHUNK (≥1) is the latency in cycles.
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iValid  input  1  operands on iA/iB/iC/iSub are valid this cycle.
- iStall  input  1  freeze entire pipeline (no register updates except reset).
- iA  input  WIDTH  operand A.
- iB  input  WIDTH  operand B.
- iC  input  1  carry-in (add mode only).
- iSub  input  1  0: A+B+iC; 1: A−B (A + ~B + 1, iC ignored).
- oValid  output  1  result on oFnc/oC/oZero valid.
- oFnc  output  WIDTH  sum/difference, modulo 2^WIDTH.
- oC  output  1  carry out of MSB; in subtract mode 1 = no borrow (A ≥ B unsigned).
- oZero  output  1  oFnc == 0 (qualified by oValid).

## Operation
- Stage 0: captures slice 0 sum and carry. Its carry-in is iC when iSub = 0, and 1 when iSub = 1. B is bitwise inverted when iSub = 1.
- Stage k (1..STAGES−1): adds slice k of A and B' (B after inversion), with the registered carry from stage k−1.
- Upper operand slices travel through skew registers so that slice k reaches stage k exactly k cycles after issue.
- Finished lower result slices travel through deskew registers so that all slices of one operation exit together.
- oC is the registered carry of stage STAGES−1.
- oZero is computed from the assembled final slices and registered alongside oFnc. Slices may be OR-reduced per stage and carried as a running flag.
- Valid bit: a valid shift register of depth STAGES. Data registers load regardless of iValid; only the valid bit qualifies outputs.
- iStall = 1: every register, valid bits included, holds its value. Inputs presented during a stall are ignored. Outputs stay stable and oValid is unchanged.
- iStall = 0: the pipeline advances one stage per cycle, and iValid = 0 inserts a bubble.
- There are no states other than pipeline occupancy, and there is no backpressure beyond iStall.
- Arithmetic is unsigned, modulo 2^WIDTH. The signed interpretation is left to the consumer (overflow is not flagged).

## Timing
- Latency: an operation issued at edge n (iValid = 1, iStall = 0) appears at edge n+STAGES with oValid = 1, provided no stall cycles intervene. Each stall cycle adds one cycle of latency.
- Throughput: one operation per non-stalled cycle. Back-to-back issues produce back-to-back results in issue order.
- Reset: while iRst = 1, all registers clear asynchronously. oValid = 0, oFnc = 0, oC = 0, oZero = 0 (registered value; not 1).
- Reset mid-operation: in-flight operations are discarded with no partial result. The first issue after iRst falls is accepted at the first rising edge at which iRst = 0.
- iStall and iRst asserted together: reset wins.
- STAGES = 1 degenerates to one registered full adder with latency 1.
- Carry chain per stage is CHUNK bits. CHUNK sets the critical path.

## Test plan
Cases 1–5 use WIDTH = 24, CHUNK = 8 (latency 3).
1. Reset: assert iRst asynchronously between edges. Required: all outputs drop to 0 immediately and oValid stays 0 until 3 cycles after the first valid issue.
2. Add with carry ripple: A = 0x00FFFF, B = 0x000001, iC = 0. Required, 3 cycles later: oFnc = 0x010000, oC = 0, oZero = 0.
3. Overflow: A = 0xFFFFFF, B = 0x000001, iC = 0. Required: oFnc = 0x000000, oC = 1, oZero = 1.
4. Subtract with borrow: iSub = 1, A = 5, B = 7, iC = 1 (must be ignored). Required: oFnc = 0xFFFFFE, oC = 0.
5. Stream with stall: issue four back-to-back ops (1+1, 2+2, 0x800000+0x800000, 10−3). Stall for 2 cycles after the second issue. Required: results 2, 4, 0 (oC = 1, oZero = 1), 7, in order. Outputs are held constant during the stall and total span is 3 + 4 + 2 − 1 cycles.
6. Reset mid-stream, then parameter sweep:
   - Reset: assert iRst with 2 ops in flight. Required: those ops are never emitted, and the next op issued after reset returns correctly.
   - Sweep: repeat random add/sub checks against a reference model for (WIDTH, CHUNK) = (8, 8), (32, 4), (11, 11).
